// File: rtl/uart_echo_initiator_pkg.sv
// Shared types and constants for the UART echo initiator: FSM state encoding,
// LFSR tap mask, seed-zero substitute and small arithmetic helpers.
package uart_echo_initiator_pkg;

  // Run sequencing states (3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ECHO = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Feedback taps at bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_echo_initiator_lfsr8.sv
// 8-bit Fibonacci LFSR pattern generator for the UART echo initiator.
// load takes priority over advance; a zero seed is substituted with 8'h01.
module uart_echo_initiator_lfsr8
  import uart_echo_initiator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] q
);

  logic [7:0] q_d;
  logic [7:0] q_q;

  // Next-value selection: hold, reload from seed, or step the sequence.
  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (load) begin
      q_d = (seed == 8'h00) ? SEED_ZERO_SUB : seed;
    end else if (advance) begin
      q_d = lfsr_next(q_q);
    end
  end

  // Pattern register, cleared to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for flops so all registers update together at the edge.
    if (!rst_n) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/uart_echo_initiator.sv
// UART echo initiator: sends a pseudo-random byte sequence through a UART_TX
// style strobe, waits for each byte to return on the UART_RX handshake,
// compares it and reports pass/fail plus a saturating error count.
// Optional feature: define UART_ECHO_TIMEOUT_EN to add a per-byte echo
// timeout; without it WAIT_ECHO waits indefinitely and o_TIMEOUT is 0.
module uart_echo_initiator
  import uart_echo_initiator_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = 16,
  parameter int unsigned GAP_CLKS     = 1000,
  parameter int unsigned TIMEOUT_CLKS = 10000
) (
  input  logic       i_CLK,
  input  logic       i_RESET_N,
  input  logic       i_START,
  input  logic [7:0] i_SEED,
  output logic       o_tx_DATA_READY,
  output logic [7:0] o_tx_DATA,
  input  logic [7:0] i_RX_DATA,
  input  logic       i_RX_DATA_READY,
  output logic       o_BUSY,
  output logic       o_DONE,
  output logic       o_PASS,
  output logic [7:0] o_ERR_CNT,
  output logic       o_TIMEOUT
);

  // Reject parameter values the counters cannot represent.
  if (NUM_BYTES < 1 || NUM_BYTES > 255 || GAP_CLKS < 1 ||
      TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 65536) begin : g_bad_params
    $error("uart_echo_initiator: parameter out of range");
  end

  localparam int unsigned GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CLKS - 1);
  localparam logic [7:0]       BYTE_LAST = 8'(NUM_BYTES - 1);

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             send_cnt_q, send_cnt_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             rx_ready_q;
  logic             rx_rise;
  logic             compare_en;
  logic             lfsr_load;
  logic             lfsr_advance;
  logic [7:0]       lfsr_q;

`ifdef UART_ECHO_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        byte_to_q, byte_to_d;
  logic        timeout_q, timeout_d;

  // A byte that timed out has no echo to compare against.
  assign compare_en = ~byte_to_q;
  assign o_TIMEOUT  = timeout_q;
`else
  assign compare_en = 1'b1;
  assign o_TIMEOUT  = 1'b0;
`endif

  // Only a fresh low-to-high transition counts as an echo event.
  assign rx_rise = i_RX_DATA_READY & ~rx_ready_q;

  uart_echo_initiator_lfsr8 u_lfsr (
    .clk     (i_CLK),
    .rst_n   (i_RESET_N),
    .load    (lfsr_load),
    .seed    (i_SEED),
    .advance (lfsr_advance),
    .q       (lfsr_q)
  );

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    send_cnt_d   = send_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rx_byte_d    = rx_byte_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;
`ifdef UART_ECHO_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    byte_to_d    = byte_to_q;
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          lfsr_load  = 1'b1;
          err_cnt_d  = 8'h00;
          pass_d     = 1'b0;
          byte_cnt_d = 8'h00;
          gap_cnt_d  = '0;
`ifdef UART_ECHO_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d  = '0;
          send_cnt_d = 1'b0;
          state_d    = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      // Strobe is held for two clocks: send_cnt marks the second one.
      ST_SEND: begin
        if (send_cnt_q) begin
          state_d = ST_WAIT_ECHO;
`ifdef UART_ECHO_TIMEOUT_EN
          to_cnt_d  = 16'h0000;
          byte_to_d = 1'b0;
`endif
        end else begin
          send_cnt_d = 1'b1;
        end
      end

      // An echo edge in the expiry clock takes priority over the timeout.
      ST_WAIT_ECHO: begin
        if (rx_rise) begin
          rx_byte_d = i_RX_DATA;
          state_d   = ST_CHECK;
        end
`ifdef UART_ECHO_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_LAST) begin
          err_cnt_d = sat_inc8(err_cnt_q);
          timeout_d = 1'b1;
          byte_to_d = 1'b1;
          state_d   = ST_CHECK;
        end else begin
          to_cnt_d = to_cnt_q + 16'h0001;
        end
`endif
      end

      ST_CHECK: begin
        if (compare_en && (rx_byte_q != lfsr_q)) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end
        lfsr_advance = 1'b1;
        if (byte_cnt_q == BYTE_LAST) begin
          pass_d  = (err_cnt_d == 8'h00);
          state_d = ST_DONE;
        end else begin
          byte_cnt_d = byte_cnt_q + 8'h01;
          state_d    = ST_GAP;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and result registers.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      send_cnt_q <= 1'b0;
      byte_cnt_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      err_cnt_q  <= 8'h00;
      pass_q     <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      send_cnt_q <= send_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_byte_q  <= rx_byte_d;
      err_cnt_q  <= err_cnt_d;
      pass_q     <= pass_d;
      rx_ready_q <= i_RX_DATA_READY;
    end
  end

`ifdef UART_ECHO_TIMEOUT_EN
  // Echo timeout counter and flags.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      to_cnt_q  <= 16'h0000;
      byte_to_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      byte_to_q <= byte_to_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign o_tx_DATA_READY = (state_q == ST_SEND);
  assign o_tx_DATA       = lfsr_q;
  assign o_BUSY          = (state_q != ST_IDLE);
  assign o_DONE          = (state_q == ST_DONE);
  assign o_PASS          = pass_q;
  assign o_ERR_CNT       = err_cnt_q;

endmodule
